// File: rtl/pri_enc_queue.sv
// Registered 8-to-3 priority encoder with request capture and a valid/ready output.
// Pending requests are served highest index first; each index retires when accepted.
module pri_enc_queue #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ei,
  input  logic [N-1:0]  req,
  input  logic          ready_i,
  output logic [CW-1:0] code_o,
  output logic          valid_o,
  output logic          gs_o,
  output logic          eo_o,
  output logic [N-1:0]  pending_o,
  output logic          ovf_o
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  clr;
  logic [CW-1:0] code_q, code_d;
  logic [CW-1:0] top_idx;
  logic          any_pending;
  logic          load;
  logic          ovf_q, ovf_d;

  // Ascending scan: the last set bit found is the highest-priority one.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        top_idx = CW'(i);
      end
    end
  end

  assign any_pending = |pending_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    load    = 1'b0;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          load = 1'b1;
        end
      end
      StPresent: begin
        if (ready_i) begin
          if (any_pending) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      code_d       = top_idx;
      clr[top_idx] = 1'b1;
      state_d      = StPresent;
    end
  end

  // A request on the bit being cleared this edge re-arms it; set wins over clear.
  always_comb begin
    pending_d = pending_q & ~clr;
    ovf_d     = ovf_q;
    if (ei) begin
      pending_d = pending_d | req;
      ovf_d     = ovf_q | (|(req & pending_q & ~clr));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = (state_q == StPresent);
  assign gs_o      = any_pending | valid_o;
  assign eo_o      = ei & ~gs_o;
  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pri_enc_queue.sv
// Bench for pri_enc_queue: directed scenarios plus random traffic, all checked
// each cycle against a set-of-indices reference model.
module tb_pri_enc_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ei;
  logic [7:0] req;
  logic       ready_i;
  logic [2:0] code_o;
  logic       valid_o, gs_o, eo_o, ovf_o;
  logic [7:0] pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of waiting indices, the presented index, sticky overflow.
  bit       m_wait [8];
  bit       m_valid;
  int       m_code;
  bit       m_ovf;

  pri_enc_queue #(.N(8), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ei        (ei),
    .req       (req),
    .ready_i   (ready_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .gs_o      (gs_o),
    .eo_o      (eo_o),
    .pending_o (pending_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_wait[i] = 0;
    m_valid = 0;
    m_code  = 0;
    m_ovf   = 0;
  endtask

  function automatic int model_busy();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_wait[i];
    return n;
  endfunction

  // One rising edge of the spec rules, using inputs as they stood before the edge.
  task automatic model_edge(input logic e, input logic [7:0] r, input logic rdy);
    int taken = -1;
    if (!m_valid || rdy) begin
      for (int i = 7; i >= 0; i--) begin
        if (m_wait[i] && taken < 0) taken = i;
      end
      if (taken >= 0) begin
        m_wait[taken] = 0;
        m_code  = taken;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (e) begin
      for (int i = 0; i < 8; i++) begin
        if (r[i]) begin
          if (m_wait[i]) m_ovf = 1;
          m_wait[i] = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_pend;
    bit         busy;
    for (int i = 0; i < 8; i++) exp_pend[i] = m_wait[i];
    busy = (model_busy() != 0) || m_valid;
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
    chk({tag, ".code"}, 32'(code_o), 32'(m_code));
    chk({tag, ".pending"}, 32'(pending_o), 32'(exp_pend));
    chk({tag, ".gs"}, 32'(gs_o), 32'(busy));
    chk({tag, ".eo"}, 32'(eo_o), 32'(ei & !busy));
    chk({tag, ".ovf"}, 32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic step(input string tag);
    logic       e_s   = ei;
    logic [7:0] r_s   = req;
    logic       rdy_s = ready_i;
    @(posedge clk);
    model_edge(e_s, r_s, rdy_s);
    #1;
    check_model(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".code"}, 32'(code_o), 32'd0);
    chk({tag, ".valid"}, 32'(valid_o), 32'd0);
    chk({tag, ".gs"}, 32'(gs_o), 32'd0);
    chk({tag, ".eo"}, 32'(eo_o), 32'd1);
    chk({tag, ".pending"}, 32'(pending_o), 32'd0);
    chk({tag, ".ovf"}, 32'(ovf_o), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ei      = 1'b1;
    req     = 8'h00;
    ready_i = 1'b1;
    model_reset();
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Single request: two edges to valid, gone one edge after acceptance.
    req = 8'h20;
    step("single_e0");
    req = 8'h00;
    step("single_e1");
    chk("single.valid", 32'(valid_o), 32'd1);
    chk("single.code", 32'(code_o), 32'd5);
    chk("single.gs", 32'(gs_o), 32'd1);
    chk("single.eo", 32'(eo_o), 32'd0);
    step("single_e2");
    chk("single_done.valid", 32'(valid_o), 32'd0);
    chk("single_done.eo", 32'(eo_o), 32'd1);

    // Multi-hot burst: back-to-back codes 7, 5, 2.
    req = 8'hA4;
    step("burst_cap");
    req = 8'h00;
    step("burst_c7");
    chk("burst.code7", 32'(code_o), 32'd7);
    step("burst_c5");
    chk("burst.code5", 32'(code_o), 32'd5);
    chk("burst.valid5", 32'(valid_o), 32'd1);
    step("burst_c2");
    chk("burst.code2", 32'(code_o), 32'd2);
    chk("burst.valid2", 32'(valid_o), 32'd1);
    step("burst_end");
    chk("burst.end_valid", 32'(valid_o), 32'd0);

    // Backpressure: 1 held, 7 arrives behind it, then 1, 7, 0.
    ready_i = 1'b0;
    req = 8'h03;
    step("bp_cap");
    req = 8'h00;
    step("bp_c1");
    chk("bp.code1", 32'(code_o), 32'd1);
    req = 8'h80;
    step("bp_hold_a");
    req = 8'h00;
    step("bp_hold_b");
    chk("bp.held", 32'(code_o), 32'd1);
    ready_i = 1'b1;
    step("bp_c7");
    chk("bp.code7", 32'(code_o), 32'd7);
    step("bp_c0");
    chk("bp.code0", 32'(code_o), 32'd0);
    chk("bp.valid0", 32'(valid_o), 32'd1);
    step("bp_end");
    chk("bp.end_valid", 32'(valid_o), 32'd0);

    // Overflow: bit 3 pending behind presented 4, re-requested twice.
    ready_i = 1'b0;
    req = 8'h18;
    step("ovf_cap");
    req = 8'h00;
    step("ovf_c4");
    chk("ovf.code4", 32'(code_o), 32'd4);
    chk("ovf.pre", 32'(ovf_o), 32'd0);
    req = 8'h08;
    step("ovf_hit1");
    chk("ovf.set", 32'(ovf_o), 32'd1);
    req = 8'h00;
    step("ovf_gap");
    req = 8'h08;
    step("ovf_hit2");
    req = 8'h00;
    ready_i = 1'b1;
    step("ovf_c3");
    chk("ovf.code3", 32'(code_o), 32'd3);
    chk("ovf.pend_empty", 32'(pending_o), 32'd0);
    step("ovf_end");
    chk("ovf.served_once", 32'(valid_o), 32'd0);
    chk("ovf.sticky", 32'(ovf_o), 32'd1);

    // Enable low: requests ignored, eo follows ei.
    ei  = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step("ei_low");
      chk("ei_low.pending", 32'(pending_o), 32'd0);
      chk("ei_low.valid", 32'(valid_o), 32'd0);
      chk("ei_low.eo", 32'(eo_o), 32'd0);
    end
    ei  = 1'b1;
    req = 8'h00;
    #1;
    chk("ei_restore.eo", 32'(eo_o), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ei      = ($urandom_range(0, 7) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      req     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step("rand");
    end
    req = 8'h00;
    ei  = 1'b1;

    // Asynchronous reset while presenting.
    ready_i = 1'b0;
    req = 8'h40;
    step("rst_cap");
    req = 8'h00;
    step("rst_present");
    chk("rst.presenting", 32'(valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    model_reset();
    #2;
    rst_n = 1'b1;
    ready_i = 1'b1;
    req = 8'h01;
    step("post_rst_cap");
    req = 8'h00;
    step("post_rst_c0");
    chk("post_rst.valid", 32'(valid_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
